// File: rtl/neptune_pkg.sv
// Shared Neptune I definitions used by the system RAM arbiter:
// arbiter state encoding and owner encoding.
package neptune_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating burst-length counter for the RAM arbiter.
// Counts granted cycles of the current owner. clr has priority over inc.
// tc flags the final cycle an owner may hold the RAM while the other
// master waits.
module arb_burst_counter #(
  parameter int burst_max = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(burst_max);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(burst_max - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == TC_VAL);

  // Next count: clear on owner entry, otherwise count up and hold at terminal
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Neptune I system RAM arbiter: CPU (control matrix) vs DMA (user interface).
// Registered grants, combinational steering of address/data/write enable,
// and a per-owner burst limit so neither master starves the other.
// Optional feature macro: RAM_ARB_DMA_LOCK_EN adds dma_lock, which keeps the
// DMA owner from being handed over on the burst limit.
module ram_arbiter
  import neptune_pkg::*;
#(
  parameter int width     = 16,
  parameter int add_width = 13,
  parameter int burst_max = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [add_width-1:0] cpu_add,
  input  logic [width-1:0]     cpu_wr,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [add_width-1:0] dma_add,
  input  logic [width-1:0]     dma_wr,
`ifdef RAM_ARB_DMA_LOCK_EN
  input  logic                 dma_lock,
`endif
  output logic                 cpu_gnt,
  output logic                 dma_gnt,
  output logic                 cpu_stall,
  output logic                 ram_we,
  output logic [add_width-1:0] ram_add,
  output logic [width-1:0]     ram_wr
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_owner_q;
  logic       last_owner_d;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_tc;
  logic       lock_hold;

`ifdef RAM_ARB_DMA_LOCK_EN
  assign lock_hold = dma_lock;
`else
  assign lock_hold = 1'b0;
`endif

  arb_burst_counter #(
    .burst_max (burst_max)
  ) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  // Next-state logic: idle tie-break on last owner, owner release/handover,
  // burst counting while the owner stays
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_req && dma_req) begin
          state_d = (last_owner_q == OWN_CPU) ? ARB_DMA : ARB_CPU;
        end else if (cpu_req) begin
          state_d = ARB_CPU;
        end else if (dma_req) begin
          state_d = ARB_DMA;
        end
      end
      ARB_CPU: begin
        if (!cpu_req) begin
          state_d = dma_req ? ARB_DMA : ARB_IDLE;
        end else if (dma_req && cnt_tc) begin
          state_d = ARB_DMA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ARB_DMA: begin
        if (!dma_req) begin
          state_d = cpu_req ? ARB_CPU : ARB_IDLE;
        end else if (cpu_req && cnt_tc && !lock_hold) begin
          state_d = ARB_CPU;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // A fresh tenure restarts the burst count and records the new owner
    if ((state_d != state_q) && (state_d != ARB_IDLE)) begin
      cnt_clr      = 1'b1;
      cnt_inc      = 1'b0;
      last_owner_d = (state_d == ARB_DMA) ? OWN_DMA : OWN_CPU;
    end
  end

  // State and last-owner registers; last owner resets to DMA so CPU wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_DMA;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Grants and RAM-side steering, decoded from the registered state
  always_comb begin
    cpu_gnt   = (state_q == ARB_CPU);
    dma_gnt   = (state_q == ARB_DMA);
    cpu_stall = cpu_req & ~cpu_gnt;
    ram_we    = (cpu_gnt & cpu_req & cpu_we) | (dma_gnt & dma_req & dma_we);
    ram_add   = dma_gnt ? dma_add : cpu_add;
    ram_wr    = dma_gnt ? dma_wr  : cpu_wr;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter (burst_max = 4). Directed scenarios followed by
// randomized traffic, every cycle compared against a tenure-based reference
// model of the arbitration rules.
module tb_ram_arbiter;

  localparam int W  = 16;
  localparam int AW = 13;
  localparam int BM = 4;

  localparam int NONE = 0;
  localparam int CPU  = 1;
  localparam int DMA  = 2;

`ifdef RAM_ARB_DMA_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [AW-1:0] cpu_add, dma_add;
  logic [W-1:0]  cpu_wr, dma_wr;
  logic          cpu_gnt, dma_gnt, cpu_stall, ram_we;
  logic [AW-1:0] ram_add;
  logic [W-1:0]  ram_wr;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the RAM, how many cycles this tenure has lasted,
  // and who last won a grant.
  int m_owner = NONE;
  int m_run   = 0;
  int m_last  = DMA;

  always #5 clk = ~clk;

  ram_arbiter #(
    .width     (W),
    .add_width (AW),
    .burst_max (BM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_add   (cpu_add),
    .cpu_wr    (cpu_wr),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_add   (dma_add),
    .dma_wr    (dma_wr),
`ifdef RAM_ARB_DMA_LOCK_EN
    .dma_lock  (dma_lock),
`endif
    .cpu_gnt   (cpu_gnt),
    .dma_gnt   (dma_gnt),
    .cpu_stall (cpu_stall),
    .ram_we    (ram_we),
    .ram_add   (ram_add),
    .ram_wr    (ram_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_owner();
    int  other;
    bit  own_req, oth_req, locked;
    if (m_owner == NONE) begin
      if (cpu_req && dma_req) return (m_last == CPU) ? DMA : CPU;
      if (cpu_req) return CPU;
      if (dma_req) return DMA;
      return NONE;
    end
    other   = (m_owner == CPU) ? DMA : CPU;
    own_req = (m_owner == CPU) ? cpu_req : dma_req;
    oth_req = (m_owner == CPU) ? dma_req : cpu_req;
    locked  = LOCK_EN && (m_owner == DMA) && dma_lock;
    if (!own_req) return oth_req ? other : NONE;
    if (oth_req && (m_run >= BM) && !locked) return other;
    return m_owner;
  endfunction

  // Let combinational outputs settle, then compare all of them with the model
  task automatic settle();
    bit exp_we;
    #1;
    exp_we = (m_owner == CPU && cpu_req && cpu_we) || (m_owner == DMA && dma_req && dma_we);
    chk("cpu_gnt",   32'(cpu_gnt),   32'(m_owner == CPU));
    chk("dma_gnt",   32'(dma_gnt),   32'(m_owner == DMA));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && (m_owner != CPU)));
    chk("ram_we",    32'(ram_we),    32'(exp_we));
    chk("ram_add",   32'(ram_add),   32'((m_owner == DMA) ? dma_add : cpu_add));
    chk("ram_wr",    32'(ram_wr),    32'((m_owner == DMA) ? dma_wr : cpu_wr));
    chk("excl",      32'(cpu_gnt & dma_gnt), 32'(0));
  endtask

  // Advance one clock and update the model from the inputs sampled at that edge
  task automatic tick();
    int nxt;
    @(posedge clk);
    if (rst) begin
      m_owner = NONE;
      m_run   = 0;
      m_last  = DMA;
    end else begin
      nxt = next_owner();
      if (nxt == NONE) begin
        m_run = 0;
      end else if (nxt != m_owner) begin
        m_run  = 1;
        m_last = nxt;
      end else begin
        m_run++;
      end
      m_owner = nxt;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic quiet();
    cpu_req  = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
    cpu_add  = '0;   cpu_wr = '0;   dma_add = '0;   dma_wr = '0;
  endtask

  initial begin
    // Reset held with both masters requesting
    rst = 1'b1;
    quiet();
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b1; dma_we = 1'b1;
    cpu_add = 13'h111; dma_add = 13'h222;
    tick();
    settle();
    chk("rst_cpu_gnt", 32'(cpu_gnt),   32'(0));
    chk("rst_dma_gnt", 32'(dma_gnt),   32'(0));
    chk("rst_ram_we",  32'(ram_we),    32'(0));
    chk("rst_stall",   32'(cpu_stall), 32'(1));
    tick();
    rst = 1'b0;
    step();
    settle();
    chk("first_tie_cpu", 32'(cpu_gnt), 32'(1));
    tick();

    // Single CPU write from idle
    rst = 1'b1; quiet(); step();
    rst = 1'b0; step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = 13'h0A5; cpu_wr = 16'hBEEF;
    dma_add = 13'h1FFF; dma_wr = 16'h1234;
    settle();
    chk("wr_gnt_latency", 32'(cpu_gnt), 32'(0));
    tick();
    settle();
    chk("wr_cpu_gnt", 32'(cpu_gnt), 32'(1));
    chk("wr_ram_we",  32'(ram_we),  32'(1));
    chk("wr_ram_add", 32'(ram_add), 32'h0A5);
    chk("wr_ram_wr",  32'(ram_wr),  32'hBEEF);
    tick();

    // Contention: both held, grants alternate in runs of BM
    rst = 1'b1; quiet(); step();
    rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; step();
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("cont_cpu", 32'(cpu_gnt), 32'(((i / BM) % 2) == 0));
      chk("cont_dma", 32'(dma_gnt), 32'(((i / BM) % 2) == 1));
      tick();
    end

    // Early release by DMA in the second cycle of its burst
    rst = 1'b1; quiet(); step();
    rst = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_add = 13'h0C3; step();
    cpu_req = 1'b1; step();
    dma_req = 1'b0;
    settle();
    chk("rel_ram_we", 32'(ram_we), 32'(0));
    tick();
    settle();
    chk("rel_cpu_gnt", 32'(cpu_gnt), 32'(1));
    tick();

    // Reset in the middle of a DMA write burst
    rst = 1'b1; quiet(); step();
    rst = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_wr = 16'h5A5A; step();
    settle();
    chk("mid_dma_gnt_pre", 32'(dma_gnt), 32'(1));
    chk("mid_ram_we_pre",  32'(ram_we),  32'(1));
    tick();
    rst = 1'b1;
    settle();
    chk("mid_ram_we_last", 32'(ram_we), 32'(1));
    tick();
    rst = 1'b0;
    settle();
    chk("mid_dma_gnt_post", 32'(dma_gnt), 32'(0));
    chk("mid_ram_we_post",  32'(ram_we),  32'(0));
    tick();

`ifdef RAM_ARB_DMA_LOCK_EN
    // Locked DMA ignores the burst limit and releases only by dropping its request
    rst = 1'b1; quiet(); step();
    rst = 1'b0; dma_req = 1'b1; step();
    cpu_req = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("lock_dma_gnt", 32'(dma_gnt), 32'(1));
      tick();
    end
    dma_req = 1'b0;
    step();
    settle();
    chk("lock_release_cpu", 32'(cpu_gnt), 32'(1));
    tick();
`endif

    // Randomized traffic against the model
    rst = 1'b1; quiet(); step();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(39, 0) == 0);
      cpu_req  = ($urandom_range(9, 0) < 6);
      dma_req  = ($urandom_range(9, 0) < 6);
      cpu_we   = $urandom_range(1, 0);
      dma_we   = $urandom_range(1, 0);
      dma_lock = ($urandom_range(3, 0) == 0);
      cpu_add  = AW'($urandom);
      dma_add  = AW'($urandom);
      cpu_wr   = W'($urandom);
      dma_wr   = W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
